// File: rtl/iob_sync_fifo_ctrl_pkg.sv
// Shared constants and sizing helpers for the synchronous FIFO controller.
package iob_sync_fifo_ctrl_pkg;

  localparam int DEF_DATA_W        = 16;
  localparam int DEF_ADDR_W        = 6;
  localparam int DEF_AFULL_MARGIN  = 1;
  localparam int DEF_AEMPTY_MARGIN = 1;

  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  // One extra bit so the level can represent a completely full FIFO.
  function automatic int level_w(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/iob_sync_fifo_ctrl_if.sv
// Requester-side handshake and status bundle of the FIFO controller.
interface iob_sync_fifo_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
);

  logic              push;
  logic [DATA_W-1:0] push_data;
  logic              pop;
  logic [DATA_W-1:0] pop_data;
  logic              pop_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   level;
  logic              overflow;
  logic              underflow;

  modport master (
    output push, push_data, pop,
    input  pop_data, pop_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );

  modport slave (
    input  push, push_data, pop,
    output pop_data, pop_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );

endinterface

// File: rtl/iob_sync_fifo_ctrl_ptr.sv
// Wrapping ADDR_W-bit FIFO pointer with advance enable and synchronous clear.
module iob_fifo_ptr #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_en,
  output logic [ADDR_W-1:0] o_ptr
);

  logic [ADDR_W-1:0] r_ptr;

  // NOTE: reset is synchronous, so it lives inside the clocked branch and
  // is absent from the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_ptr <= '0;
    end else if (i_en) begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples the pre-edge values, independent of statement order.
      r_ptr <= r_ptr + ADDR_W'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/iob_sync_fifo_ctrl.sv
// Single-clock FIFO controller sequencing an external registered-read
// two-port memory; owns pointers, occupancy, status and sticky error flags.
module iob_sync_fifo_ctrl
  import iob_sync_fifo_ctrl_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int AFULL_MARGIN  = DEF_AFULL_MARGIN,
  parameter int AEMPTY_MARGIN = DEF_AEMPTY_MARGIN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clear,
  iob_sync_fifo_ctrl_if.slave bus,
  output logic                o_mem_w_en,
  output logic [ADDR_W-1:0]   o_mem_w_addr,
  output logic [DATA_W-1:0]   o_mem_w_data,
  output logic                o_mem_r_en,
  output logic [ADDR_W-1:0]   o_mem_r_addr,
  input  logic [DATA_W-1:0]   i_mem_r_data
);

  localparam int DEPTH = fifo_depth(ADDR_W);
  localparam int LVL_W = level_w(ADDR_W);

  localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_AFULL  = LVL_W'(DEPTH - AFULL_MARGIN);
  localparam logic [LVL_W-1:0] LVL_AEMPTY = LVL_W'(AEMPTY_MARGIN);
  localparam logic [LVL_W-1:0] LVL_ONE    = LVL_W'(1);

  logic [LVL_W-1:0] r_level;
  logic             r_pop_valid;
  logic             r_overflow;
  logic             r_underflow;

  logic [LVL_W-1:0] w_level_nxt;
  logic             w_full;
  logic             w_empty;
  logic             w_push_ok;
  logic             w_pop_ok;

  // Status decodes straight from the level register; accepts use it too,
  // so a full FIFO never takes a push even when a pop frees a slot.
  assign w_full    = (r_level == LVL_FULL);
  assign w_empty   = (r_level == '0);
  assign w_push_ok = bus.push & ~w_full;
  assign w_pop_ok  = bus.pop  & ~w_empty;

  iob_fifo_ptr #(.ADDR_W(ADDR_W)) u_w_ptr (
    .clk     (clk),
    .rst     (rst),
    .i_clear (i_clear),
    .i_en    (w_push_ok),
    .o_ptr   (o_mem_w_addr)
  );

  iob_fifo_ptr #(.ADDR_W(ADDR_W)) u_r_ptr (
    .clk     (clk),
    .rst     (rst),
    .i_clear (i_clear),
    .i_en    (w_pop_ok),
    .o_ptr   (o_mem_r_addr)
  );

  always_comb begin
    // NOTE: default first, so no path through the case leaves the signal
    // unassigned and infers a latch.
    w_level_nxt = r_level;
    unique case ({w_push_ok, w_pop_ok})
      2'b10:   w_level_nxt = r_level + LVL_ONE;
      2'b01:   w_level_nxt = r_level - LVL_ONE;
      default: w_level_nxt = r_level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_level     <= '0;
      r_pop_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_level     <= w_level_nxt;
      r_pop_valid <= w_pop_ok;
      r_overflow  <= r_overflow  | (bus.push & w_full);
      r_underflow <= r_underflow | (bus.pop  & w_empty);
    end
  end

  assign o_mem_w_en   = w_push_ok;
  assign o_mem_w_data = bus.push_data;
  assign o_mem_r_en   = w_pop_ok;

  assign bus.pop_data     = i_mem_r_data;
  assign bus.pop_valid    = r_pop_valid;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_level >= LVL_AFULL);
  assign bus.almost_empty = (r_level <= LVL_AEMPTY);
  assign bus.level        = r_level;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_iob_sync_fifo_ctrl.sv
// Self-checking bench: directed scenarios then random traffic, all compared
// against a queue-based FIFO model with a simple registered-read memory.
module tb_iob_sync_fifo_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic clear;
  always #5 clk = ~clk;

  iob_sync_fifo_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  logic          mem_w_en;
  logic [AW-1:0] mem_w_addr;
  logic [DW-1:0] mem_w_data;
  logic          mem_r_en;
  logic [AW-1:0] mem_r_addr;
  logic [DW-1:0] mem_r_data;
  logic [DW-1:0] mem [DEPTH];

  always @(posedge clk) begin
    if (mem_w_en) mem[mem_w_addr] <= mem_w_data;
    if (mem_r_en) mem_r_data <= mem[mem_r_addr];
  end

  iob_sync_fifo_ctrl #(
    .DATA_W(DW), .ADDR_W(AW), .AFULL_MARGIN(1), .AEMPTY_MARGIN(1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (clear),
    .bus          (bus),
    .o_mem_w_en   (mem_w_en),
    .o_mem_w_addr (mem_w_addr),
    .o_mem_w_data (mem_w_data),
    .o_mem_r_en   (mem_r_en),
    .o_mem_r_addr (mem_r_addr),
    .i_mem_r_data (mem_r_data)
  );

  // Reference model: contents as a queue, addresses as running counts.
  logic [DW-1:0] q[$];
  int            wcnt, rcnt;
  bit            m_ovf, m_udf, m_valid, m_ready;
  logic [DW-1:0] m_data;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status();
    check("level",        32'(bus.level),        32'(q.size()));
    check("empty",        32'(bus.empty),        32'(q.size() == 0));
    check("full",         32'(bus.full),         32'(q.size() == DEPTH));
    check("almost_full",  32'(bus.almost_full),  32'(q.size() >= DEPTH - 1));
    check("almost_empty", 32'(bus.almost_empty), 32'(q.size() <= 1));
    check("overflow",     32'(bus.overflow),     32'(m_ovf));
    check("underflow",    32'(bus.underflow),    32'(m_udf));
    check("pop_valid",    32'(bus.pop_valid),    32'(m_valid));
    if (m_valid) check("pop_data", 32'(bus.pop_data), 32'(m_data));
  endtask

  // One clock cycle: drive, check memory-port decode, clock, update model, check status.
  task automatic step(input bit r, input bit c, input bit ph, input logic [DW-1:0] d, input bit pp);
    bit m_full, m_empty, p_ok, q_ok;
    rst = r; clear = c;
    bus.push = ph; bus.push_data = d; bus.pop = pp;
    m_full  = (q.size() == DEPTH);
    m_empty = (q.size() == 0);
    p_ok    = ph && !m_full;
    q_ok    = pp && !m_empty;
    #1;
    if (m_ready) begin
      check("mem_w_en",   32'(mem_w_en),   32'(p_ok));
      check("mem_r_en",   32'(mem_r_en),   32'(q_ok));
      check("mem_w_addr", 32'(mem_w_addr), 32'(wcnt % DEPTH));
      check("mem_r_addr", 32'(mem_r_addr), 32'(rcnt % DEPTH));
      check("mem_w_data", 32'(mem_w_data), 32'(d));
    end
    @(posedge clk);
    #1;
    if (r || c) begin
      q.delete();
      wcnt = 0; rcnt = 0;
      m_ovf = 0; m_udf = 0; m_valid = 0;
      m_ready = 1;
    end else begin
      m_valid = q_ok;
      if (q_ok) begin m_data = q.pop_front(); rcnt++; end
      if (p_ok) begin q.push_back(d); wcnt++; end
      m_ovf = m_ovf | (ph && m_full);
      m_udf = m_udf | (pp && m_empty);
    end
    if (m_ready) check_status();
  endtask

  initial begin
    int ppush, ppop;
    m_ready = 0;
    rst = 1'b1; clear = 1'b0;
    bus.push = 1'b0; bus.push_data = '0; bus.pop = 1'b0;

    // Reset then idle.
    step(1, 0, 0, 8'h00, 0);
    step(1, 0, 0, 8'h00, 0);
    step(0, 0, 0, 8'h00, 0);

    // Fill to full, then one rejected push.
    step(0, 0, 1, 8'h11, 0);
    step(0, 0, 1, 8'h22, 0);
    step(0, 0, 1, 8'h33, 0);
    step(0, 0, 1, 8'h44, 0);
    step(0, 0, 1, 8'h55, 0);

    // Drain back-to-back, then one rejected pop.
    for (int i = 0; i < 5; i++) step(0, 0, 0, 8'h00, 1);
    step(0, 0, 0, 8'h00, 0);

    // Wrap-around with level held at 2.
    step(0, 0, 1, 8'hA1, 0);
    step(0, 0, 1, 8'hA2, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, DW'(8'hB0 + i), 1);
    step(0, 0, 0, 8'h00, 1);
    step(0, 0, 0, 8'h00, 1);

    // Simultaneous push+pop at empty, then at full.
    step(0, 0, 1, 8'hC1, 1);
    step(0, 0, 1, 8'hC2, 0);
    step(0, 0, 1, 8'hC3, 0);
    step(0, 0, 1, 8'hC4, 0);
    step(0, 0, 1, 8'hC5, 1);
    step(0, 0, 0, 8'h00, 0);

    // Clear right after a pop: pending pop_valid cancelled, clear beats push/pop.
    step(0, 1, 0, 8'h00, 0);
    step(0, 0, 1, 8'hD1, 0);
    step(0, 0, 1, 8'hD2, 0);
    step(0, 0, 0, 8'h00, 1);
    step(0, 1, 1, 8'hEE, 1);
    step(0, 0, 1, 8'hAA, 0);
    step(0, 0, 0, 8'h00, 1);
    step(0, 0, 0, 8'h00, 0);

    // Random traffic in fill-biased, drain-biased and balanced phases.
    for (int i = 0; i < 360; i++) begin
      ppush = (i < 120) ? 75 : (i < 240) ? 30 : 55;
      ppop  = (i < 120) ? 30 : (i < 240) ? 75 : 55;
      step(($urandom_range(99) < 1), ($urandom_range(99) < 3),
           ($urandom_range(99) < ppush), DW'($urandom), ($urandom_range(99) < ppop));
    end
    step(0, 0, 0, 8'h00, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
